// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sharing of one 8x8 wallace_tree_approx multiplier among NREQ
// requesters behind a two-stage pipeline. Define MULT_SHARE_ARB_FIXED_PRIO_EN for fixed priority.

module wallace_tree_approx (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s, c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++)
      pp[i] = {8'h00, a_i & {8{b_i[i]}}} << i;
  end

  // 8 -> 6 -> 4 -> 3 -> 2 rows; the product fits 16 bits so dropped top carries are harmless
  assign {s0, c0} = csa(pp[0], pp[1], pp[2]);
  assign {s1, c1} = csa(pp[3], pp[4], pp[5]);
  assign {s2, c2} = csa(s0, c0, s1);
  assign {s3, c3} = csa(c1, pp[6], pp[7]);
  assign {s4, c4} = csa(s2, c2, s3);
  assign {s5, c5} = csa(s4, c4, c3);
  assign p_o = s5 + c5;
endmodule

module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_product,
  output logic              busy
);
  logic           v1_q, v2_q;
  logic [7:0]     a1_q, b1_q;
  logic [IDW-1:0] id1_q, id2_q, ptr_q, ptr_d;
  logic [15:0]    prod_q, mult_p;
  logic           adv1, adv2, found, accept;
  logic [IDW-1:0] gnt;
  logic [7:0]     gnt_a, gnt_b;

  assign adv2 = !v2_q || rsp_ready;
  assign adv1 = !v1_q || adv2;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_valid[j] &&
            ((int'(ptr_q) + k == j) || (int'(ptr_q) + k == j + NREQ))) begin
          found = 1'b1;
          gnt   = IDW'(j);
        end
      end
    end
  end

  always_comb begin
    gnt_a     = '0;
    gnt_b     = '0;
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (found && gnt == IDW'(j)) begin
        gnt_a        = req_a[8*j +: 8];
        gnt_b        = req_b[8*j +: 8];
        req_ready[j] = adv1 && !rst;
      end
    end
  end

  assign accept = found && adv1 && !rst;

  always_comb begin
    ptr_d = ptr_q;
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    if (accept)
      ptr_d = (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
`endif
  end

  wallace_tree_approx u_mult (
    .a_i (a1_q),
    .b_i (b1_q),
    .p_o (mult_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      id1_q  <= '0;
      id2_q  <= '0;
      prod_q <= '0;
      ptr_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (adv1) begin
        v1_q <= found;
        if (found) begin
          a1_q  <= gnt_a;
          b1_q  <= gnt_b;
          id1_q <= gnt;
        end
      end
      // S2 keeps its last result when S1 is empty so rsp_* never glitch
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          prod_q <= mult_p;
          id2_q  <= id1_q;
        end
      end
    end
  end

  assign rsp_valid   = v2_q;
  assign rsp_id      = id2_q;
  assign rsp_product = prod_q;
  assign busy        = v1_q | v2_q;
endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed scenarios with literal expectations plus a
// transaction-level model compared every cycle.
module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [8*NREQ-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_product;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_log[$];
  int rid_log[$];
  int rp_log[$];
  int rc_log[$];

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endfunction

  function automatic int acc_at(int i);
    return (i >= 0 && i < acc_log.size()) ? acc_log[i] : -1;
  endfunction
  function automatic int rid_at(int i);
    return (i >= 0 && i < rid_log.size()) ? rid_log[i] : -1;
  endfunction
  function automatic int rp_at(int i);
    return (i >= 0 && i < rp_log.size()) ? rp_log[i] : -1;
  endfunction
  function automatic int rc_at(int i);
    return (i >= 0 && i < rc_log.size()) ? rc_log[i] : -1;
  endfunction

  // Reference: two in-flight slots, a rotating pointer, and plain a*b.
  bit m_ok = 1'b0;
  bit m1v, m2v;
  int m1id, m2id, m1p, m2p, m_ptr;

  always @(negedge clk) begin
    int g, j;
    bit fnd, a1, a2;
    logic [NREQ-1:0] er;
    a2  = !m2v || rsp_ready;
    a1  = !m1v || a2;
    fnd = 1'b0;
    g   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (!fnd && req_valid[j[IDW-1:0]]) begin
        fnd = 1'b1;
        g   = j;
      end
    end
    er = '0;
    if (!rst && fnd && a1) er[g[IDW-1:0]] = 1'b1;
    if (m_ok) begin
      check("model_req_ready", int'(req_ready), int'(er));
      check("model_rsp_valid", int'(rsp_valid), int'(m2v));
      check("model_busy", int'(busy), int'(m1v | m2v));
      if (m2v) begin
        check("model_rsp_id", int'(rsp_id), m2id);
        check("model_rsp_product", int'(rsp_product), m2p);
      end
    end
    if (rst) begin
      m1v = 1'b0; m2v = 1'b0; m_ptr = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (a2) begin
        m2v = m1v; m2id = m1id; m2p = m1p;
      end
      if (a1) begin
        m1v = fnd;
        if (fnd) begin
          m1id = g;
          m1p  = int'(req_a[8*g +: 8]) * int'(req_b[8*g +: 8]);
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
          m_ptr = 0;
`else
          m_ptr = (g + 1) % NREQ;
`endif
        end
      end
    end
  end

  // One clock: sample handshakes mid-cycle, then retire accepted requests after the edge.
  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) acc_log.push_back(i);
    if (rsp_valid && rsp_ready && !rst) begin
      rid_log.push_back(int'(rsp_id));
      rp_log.push_back(int'(rsp_product));
      rc_log.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[8*i +: 8] = a[7:0];
    req_b[8*i +: 8] = b[7:0];
    req_valid[i]    = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || req_valid != '0) && n < 60) begin
      tick();
      n++;
    end
    check("drain_idle", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int m, r, m3, p, cnt3;
    int exp2[4];
    int exp3[3];
    exp2 = '{35, 225, 5000, 65025};
    exp3 = '{12, 42, 72};
    rst = 1'b1; rsp_ready = 1'b1; req_a = '0; req_b = '0; req_valid = '0;

    // reset: a pending request must not be granted while rst is high
    set_req(0, 1, 1);
    tick(); tick();
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_product", int'(rsp_product), 0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // single request, latency
    m = acc_log.size();
    set_req(2, 12, 3);
    tick();
    check("t1_grant", acc_at(m), 2);
    check("t1_busy", int'(busy), 1);
    check("t1_not_yet", int'(rsp_valid), 0);
    tick();
    check("t1_rsp_valid", int'(rsp_valid), 1);
    check("t1_rsp_id", int'(rsp_id), 2);
    check("t1_rsp_product", int'(rsp_product), 36);
    drain();

    // wrap: grant 3, then 0 and 3 -> 0 first
    m = acc_log.size();
    set_req(3, 9, 9);
    tick();
    set_req(0, 2, 5);
    set_req(3, 10, 10);
    tick(); tick();
    check("wrap_g0", acc_at(m), 3);
    check("wrap_g1", acc_at(m + 1), 0);
    check("wrap_g2", acc_at(m + 2), 3);
    drain();

    // all four at once, back-to-back
    m = acc_log.size();
    r = rid_log.size();
    set_req(0, 5, 7);
    set_req(1, 15, 15);
    set_req(2, 100, 50);
    set_req(3, 255, 255);
    drain();
    for (int k = 0; k < 4; k++) begin
      check("all4_grant", acc_at(m + k), k);
      check("all4_rsp_id", rid_at(r + k), k);
      check("all4_rsp_product", rp_at(r + k), exp2[k]);
      if (k > 0) check("all4_b2b", rc_at(r + k) - rc_at(r + k - 1), 1);
    end

    // back-pressure
    rsp_ready = 1'b0;
    m = acc_log.size();
    r = rid_log.size();
    set_req(0, 3, 4);
    set_req(1, 6, 7);
    tick(); tick();
    set_req(2, 8, 9);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_rsp_valid", int'(rsp_valid), 1);
      check("stall_rsp_id", int'(rsp_id), 0);
      check("stall_rsp_product", int'(rsp_product), 12);
    end
    check("stall_accepts", acc_log.size() - m, 2);
    check("stall_req_ready", int'(req_ready), 0);
    rsp_ready = 1'b1;
    drain();
    check("stall_rsp_count", rid_log.size() - r, 3);
    for (int k = 0; k < 3; k++) begin
      check("stall_rel_id", rid_at(r + k), k);
      check("stall_rel_product", rp_at(r + k), exp3[k]);
    end

    // fairness: 0 always requesting, 3 requests once
    m3 = -1;
    set_req(0, 1, 1);
    for (int it = 0; it < 8; it++) begin
      tick();
      if (!req_valid[0]) set_req(0, it + 2, 3);
      if (it == 1) begin
        set_req(3, 4, 4);
        m3 = acc_log.size();
      end
    end
    cnt3 = 0;
    p = -1;
    for (int i = m3; i < acc_log.size(); i++) begin
      if (acc_log[i] == 3) begin
        cnt3++;
        if (p < 0) p = i;
      end
    end
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
    check("fixed_3_starved", cnt3, 0);
    drain();
    check("fixed_3_after_0", acc_at(acc_log.size() - 1), 3);
`else
    check("rr_3_within_2", int'(p >= 0 && (p - m3) < 2), 1);
    check("rr_3_once", cnt3, 1);
    drain();
`endif

    // reset mid-flight
    m = acc_log.size();
    set_req(1, 200, 200);
    tick();
    check("rstmid_grant", acc_at(m), 1);
    r = rid_log.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_rsp_valid", int'(rsp_valid), 0);
    check("rstmid_busy", int'(busy), 0);
    tick(); tick(); tick();
    check("rstmid_no_stale", rid_log.size() - r, 0);
    m = acc_log.size();
    set_req(1, 2, 2);
    set_req(3, 3, 3);
    tick(); tick();
    check("rstmid_ptr0_g0", acc_at(m), 1);
    check("rstmid_ptr0_g1", acc_at(m + 1), 3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
